// File: rtl/nibble_io_pkg.sv
// Shared types and bit positions for the nibble I/O port peripherals.
// NIBBLE_UART_TX_PARITY_EN adds the PARITY transmit state.
package nibble_io_pkg;

`ifdef NIBBLE_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;
`endif

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;

   localparam int CTRL_SEND = 0;
   localparam int CTRL_CLR  = 1;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO; a push while full is accepted only when a pop frees a slot
// in the same cycle.
module byte_fifo import nibble_io_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

endmodule

// File: rtl/nibble_uart_tx.sv
// Port-mapped 8N1 transmitter fed from two output-port nibbles via a byte FIFO.
// Define NIBBLE_UART_TX_PARITY_EN to append an even-parity bit before STOP.
module nibble_uart_tx import nibble_io_pkg::*; #(
   parameter int N       = 4,
   parameter int CLK_DIV = 16,
   parameter int DEPTH   = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] lo_nib,
   input  logic [N-1:0] hi_nib,
   input  logic [N-1:0] ctrl,
   output logic [N-1:0] status,
   output logic         txd
);

   localparam logic [7:0] BAUD_LAST = 8'(CLK_DIV - 1);

   logic [1:0] ctrl_q;
   logic       push;
   logic       clr;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       overflow;
   tx_state_t  state;
   logic [7:0] shift;
   logic [7:0] baud;
   logic [2:0] bit_cnt;
   logic       baud_end;
`ifdef NIBBLE_UART_TX_PARITY_EN
   logic       parity;
`endif
   logic       ctrl_unused;

   assign ctrl_unused = &{1'b0, ctrl[N-1:2]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ctrl_q <= 2'b00;
      else        ctrl_q <= ctrl[1:0];
   end

   assign push = ctrl[CTRL_SEND] & ~ctrl_q[CTRL_SEND];
   assign clr  = ctrl[CTRL_CLR]  & ~ctrl_q[CTRL_CLR];
   assign pop  = (state == IDLE) & ~fifo_empty;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({hi_nib, lo_nib}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A push is only lost when the FIFO is full and nothing drains this cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                           overflow <= 1'b0;
      else if (push & fifo_full & ~pop)     overflow <= 1'b1;
      else if (clr)                         overflow <= 1'b0;
   end

   assign baud_end = (baud == BAUD_LAST);

   // txd is registered alongside the state so it changes exactly on state entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shift   <= 8'h00;
         baud    <= 8'h00;
         bit_cnt <= 3'd0;
         txd     <= 1'b1;
`ifdef NIBBLE_UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (pop) begin
                  shift   <= fifo_dout;
`ifdef NIBBLE_UART_TX_PARITY_EN
                  parity  <= ^fifo_dout;
`endif
                  bit_cnt <= 3'd0;
                  baud    <= 8'h00;
                  state   <= START;
                  txd     <= 1'b0;
               end
            end
            START: begin
               if (baud_end) begin
                  baud  <= 8'h00;
                  state <= DATA;
                  txd   <= shift[0];
               end else begin
                  baud <= baud + 8'd1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud  <= 8'h00;
                  shift <= {1'b0, shift[7:1]};
                  if (bit_cnt == 3'd7) begin
`ifdef NIBBLE_UART_TX_PARITY_EN
                     state <= PARITY;
                     txd   <= parity;
`else
                     state <= STOP;
                     txd   <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     txd     <= shift[1];
                  end
               end else begin
                  baud <= baud + 8'd1;
               end
            end
`ifdef NIBBLE_UART_TX_PARITY_EN
            PARITY: begin
               if (baud_end) begin
                  baud  <= 8'h00;
                  state <= STOP;
                  txd   <= 1'b1;
               end else begin
                  baud <= baud + 8'd1;
               end
            end
`endif
            STOP: begin
               if (baud_end) begin
                  baud  <= 8'h00;
                  state <= IDLE;
                  txd   <= 1'b1;
               end else begin
                  baud <= baud + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      status             = '0;
      status[STAT_BUSY]  = (state != IDLE);
      status[STAT_FULL]  = fifo_full;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_OVF]   = overflow;
   end

endmodule

// File: tb/tb_nibble_uart_tx.sv
// Directed bench for nibble_uart_tx: table-driven single frames plus queue,
// overflow, full-with-pop, held-send and mid-frame reset sequences.
module tb_nibble_uart_tx;

   localparam int D      = 4;
   localparam int DEP    = 4;
   localparam int BUDGET = 300;
`ifdef NIBBLE_UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic [3:0] lo_nib = 4'h0;
   logic [3:0] hi_nib = 4'h0;
   logic [3:0] ctrl   = 4'h0;
   logic [3:0] status;
   logic       txd;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] lo;
      logic [3:0] hi;
      logic [9:0] frame;
      logic       par;
   } vec_t;

   vec_t vecs[6];

   nibble_uart_tx #(.N(4), .CLK_DIV(D), .DEPTH(DEP)) dut (
      .clk    (clk),
      .reset  (reset),
      .lo_nib (lo_nib),
      .hi_nib (hi_nib),
      .ctrl   (ctrl),
      .status (status),
      .txd    (txd)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] c);
      lo_nib = lo;
      hi_nib = hi;
      ctrl   = c;
      tick;
      ctrl   = 4'h0;
   endtask

   task automatic pushByte(input logic [7:0] b);
      applyStimulus(b[3:0], b[7:4], 4'b0001);
      tick;
   endtask

   task automatic waitIdle;
      int n = 0;
      while (status[0] !== 1'b0 && n < BUDGET) begin
         tick;
         n++;
      end
      checkOutput("idle_reached", 16'(status[0]), 16'd0);
   endtask

   // Returns at the middle of the stop bit.
   task automatic captureFrame(output logic [7:0] data, output logic par,
                               output logic stop, output int waited);
      waited = 0;
      while (txd !== 1'b0 && waited < BUDGET) begin
         tick;
         waited++;
      end
      checkOutput("start_bit", 16'(txd), 16'd0);
      repeat (D / 2) tick;
      for (int i = 0; i < 8; i++) begin
         repeat (D) tick;
         data[i] = txd;
      end
      par = 1'b0;
`ifdef NIBBLE_UART_TX_PARITY_EN
      repeat (D) tick;
      par = txd;
`endif
      repeat (D) tick;
      stop = txd;
   endtask

   function automatic logic expBit(input vec_t v, input int i);
`ifdef NIBBLE_UART_TX_PARITY_EN
      if (i == 9)  return v.par;
      if (i == 10) return v.frame[9];
`endif
      return v.frame[i];
   endfunction

   task automatic checkQueue(input string tag, input logic [7:0] bytes[5], input logic pars[5],
                             input int cnt, input int first_wait);
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         waited;
      for (int i = 0; i < cnt; i++) begin
         captureFrame(data, par, stop, waited);
         checkOutput($sformatf("%s_byte%0d", tag, i), 16'(data), 16'(bytes[i]));
         checkOutput($sformatf("%s_stop%0d", tag, i), 16'(stop), 16'd1);
         checkOutput($sformatf("%s_gap%0d", tag, i), 16'(waited),
                     (i == 0) ? 16'(first_wait) : 16'(D - D / 2 + 1));
`ifdef NIBBLE_UART_TX_PARITY_EN
         checkOutput($sformatf("%s_par%0d", tag, i), 16'(par), 16'(pars[i]));
`endif
      end
      repeat (D - D / 2) tick;
   endtask

   task automatic checkQuiet(input string tag, input int cycles);
      logic busy_seen = 1'b0;
      logic low_seen  = 1'b0;
      repeat (cycles) begin
         if (status[0]) busy_seen = 1'b1;
         if (!txd)      low_seen  = 1'b1;
         tick;
      end
      checkOutput({tag, "_no_busy"}, 16'(busy_seen), 16'd0);
      checkOutput({tag, "_line_idle"}, 16'(low_seen), 16'd0);
      checkOutput({tag, "_status"}, 16'(status), 16'h4);
   endtask

   initial begin
      logic [7:0] qb[5];
      logic       qp[5];
      logic       got;
      logic       prev;
      int         rises;

      vecs[0] = '{4'h5, 4'hA, 10'b1101001010, 1'b0};
      vecs[1] = '{4'h0, 4'h0, 10'b1000000000, 1'b0};
      vecs[2] = '{4'hF, 4'hF, 10'b1111111110, 1'b0};
      vecs[3] = '{4'h7, 4'h0, 10'b1000001110, 1'b1};
      vecs[4] = '{4'h3, 4'h0, 10'b1000000110, 1'b0};
      vecs[5] = '{4'hF, 4'h1, 10'b1000111110, 1'b1};

      #3 reset = 1'b0;
      #9;
      checkOutput("reset_txd", 16'(txd), 16'd1);
      checkOutput("reset_status", 16'(status), 16'h4);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) tick;
      checkOutput("post_reset_txd", 16'(txd), 16'd1);
      checkOutput("post_reset_status", 16'(status), 16'h4);

      $display("[TB] single-frame vectors");
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].lo, vecs[v].hi, 4'b0001);
         checkOutput($sformatf("vec%0d_pushed_status", v), 16'(status), 16'h0);
         tick;
         checkOutput($sformatf("vec%0d_busy_status", v), 16'(status), 16'h5);
         for (int b = 0; b < FB; b++) begin
            got = expBit(vecs[v], b);
            for (int c = 0; c < D; c++) begin
               if (txd !== expBit(vecs[v], b)) got = txd;
               tick;
            end
            checkOutput($sformatf("vec%0d_bit%0d", v, b), 16'(got), 16'(expBit(vecs[v], b)));
         end
         checkOutput($sformatf("vec%0d_end_txd", v), 16'(txd), 16'd1);
         checkOutput($sformatf("vec%0d_end_status", v), 16'(status), 16'h4);
         tick;
      end

      $display("[TB] queue and overflow");
      pushByte(8'h01);
      pushByte(8'h02);
      pushByte(8'h03);
      pushByte(8'h04);
      pushByte(8'h05);
      checkOutput("q_full_status", 16'(status), 16'h3);
      pushByte(8'h06);
      checkOutput("q_ovf_status", 16'(status), 16'hB);
      repeat (3) tick;
      checkOutput("q_ovf_sticky", 16'(status), 16'hB);
      applyStimulus(4'h0, 4'h0, 4'b0010);
      checkOutput("q_ovf_cleared", 16'(status), 16'h3);
      waitIdle;
      qb = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
      qp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      checkQueue("q", qb, qp, 4, 1);
      checkQuiet("q_after", 60);

      $display("[TB] push while full with simultaneous pop");
      pushByte(8'h11);
      pushByte(8'h22);
      pushByte(8'h33);
      pushByte(8'h44);
      pushByte(8'h55);
      checkOutput("fp_full_status", 16'(status), 16'h3);
      waitIdle;
      checkOutput("fp_idle_status", 16'(status), 16'h2);
      applyStimulus(4'h6, 4'h6, 4'b0001);
      checkOutput("fp_after_status", 16'(status), 16'h3);
      qb = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      qp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checkQueue("fp", qb, qp, 5, 0);
      checkQuiet("fp_after", 20);

      $display("[TB] held send");
      lo_nib = 4'hC;
      hi_nib = 4'h3;
      ctrl   = 4'b0001;
      rises  = 0;
      prev   = status[0];
      repeat (50) begin
         tick;
         if (status[0] && !prev) rises++;
         prev = status[0];
      end
      ctrl = 4'h0;
      repeat (60) begin
         tick;
         if (status[0] && !prev) rises++;
         prev = status[0];
      end
      checkOutput("held_frames", 16'(rises), 16'd1);
      checkOutput("held_status", 16'(status), 16'h4);

      $display("[TB] reset mid-frame");
      pushByte(8'hA5);
      pushByte(8'h5A);
      repeat (15) tick;
      checkOutput("mid_pre_txd", 16'(txd), 16'd0);
      checkOutput("mid_pre_status", 16'(status), 16'h1);
      #1 reset = 1'b0;
      #1;
      checkOutput("mid_reset_txd", 16'(txd), 16'd1);
      checkOutput("mid_reset_status", 16'(status), 16'h4);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick;
      checkQuiet("mid_after", 60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
